// File: rtl/load_store_unit_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : load_store_unit_if                                            |
// | Purpose  : Bundles the request/response handshake and the word-only      |
// |            memory port of the load/store unit.                           |
// | Signals  : req*  - request from execute stage (valid/ready)              |
// |            resp* - response back to the pipeline (valid/ready)           |
// |            mem*  - word-aligned address, readWrite flag, data to memory  |
// | Modports : slave  - the load/store unit itself                           |
// |            master - pipeline + memory side driving the unit              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface load_store_unit_if;
  logic        reqValid;
  logic        reqReady;
  logic        reqWrite;
  logic [1:0]  reqSize;
  logic        reqUnsigned;
  logic [31:0] reqAddress;
  logic [31:0] reqWriteData;
  logic        respValid;
  logic        respReady;
  logic [31:0] respReadData;
  logic        respError;
  logic [31:0] memAddress;
  logic        memReadWrite;
  logic [31:0] memWriteData;
  logic [31:0] memReadData;

  modport slave (
    input  reqValid, reqWrite, reqSize, reqUnsigned, reqAddress, reqWriteData,
    input  respReady, memReadData,
    output reqReady, respValid, respReadData, respError,
    output memAddress, memReadWrite, memWriteData
  );

  modport master (
    output reqValid, reqWrite, reqSize, reqUnsigned, reqAddress, reqWriteData,
    output respReady, memReadData,
    input  reqReady, respValid, respReadData, respError,
    input  memAddress, memReadWrite, memWriteData
  );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : load_store_unit                                               |
// | Purpose  : Byte/half/word load-store engine between execute stage and    |
// |            a word-only ROM/RAM port. Read-modify-write for sub-word      |
// |            stores, lane extraction and sign/zero extension for loads.    |
// | Ports    : clk     - rising-edge clock                                   |
// |            reset_n - asynchronous active-low reset                       |
// |            bus     - load_store_unit_if.slave (request, response, mem)   |
// | Options  : LSU_BOUNDS_CHECK_EN - when defined, any address with bits     |
// |            above RAM_SELECT_BIT set is rejected with respError.          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module load_store_unit #(
  parameter int RAM_SELECT_BIT  = 10,
  parameter int WORD_INDEX_BITS = 8
) (
  input  wire logic       clk,
  input  wire logic       reset_n,
  load_store_unit_if.slave bus
);

  localparam logic [1:0] c_SIZE_BYTE = 2'b00;
  localparam logic [1:0] c_SIZE_HALF = 2'b01;
  localparam logic [1:0] c_SIZE_WORD = 2'b10;
  localparam logic [1:0] c_SIZE_BAD  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_write;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [1:0]  r_lane;
  logic [15:0] r_wdata;      // only the low half is needed for sub-word merges
  logic        r_req_ready;
  logic        r_resp_valid;
  logic [31:0] r_resp_data;
  logic        r_resp_error;
  logic [31:0] r_mem_addr;
  logic        r_mem_rw;
  logic [31:0] r_mem_wdata;

  logic        w_accept;
  logic        w_size_err;
  logic        w_align_err;
  logic        w_rom_store_err;
  logic        w_oob_err;
  logic        w_req_err;
  logic [31:0] w_word_addr;
  logic [7:0]  w_lane_byte;
  logic [15:0] w_lane_half;
  logic [31:0] w_load_ext;
  logic [31:0] w_merged;

  assign w_accept        = bus.reqValid && r_req_ready;
  assign w_size_err      = (bus.reqSize == c_SIZE_BAD);
  assign w_align_err     = ((bus.reqSize == c_SIZE_HALF) && bus.reqAddress[0]) ||
                           ((bus.reqSize == c_SIZE_WORD) && (bus.reqAddress[1:0] != 2'b00));
  assign w_rom_store_err = bus.reqWrite && !bus.reqAddress[RAM_SELECT_BIT];

`ifdef LSU_BOUNDS_CHECK_EN
  assign w_oob_err = |bus.reqAddress[31:RAM_SELECT_BIT+1];
`else
  // Upper bits pass through to the memory, which aliases them.
  assign w_oob_err = 1'b0;
`endif

  assign w_req_err = w_size_err || w_align_err || w_rom_store_err || w_oob_err;

  // Word-aligned address, with the RAM word-index field called out explicitly.
  assign w_word_addr = {bus.reqAddress[31:2+WORD_INDEX_BITS],
                        bus.reqAddress[2 +: WORD_INDEX_BITS], 2'b00};

  // Load path: pick the addressed lane out of the word currently on memReadData.
  always_comb begin
    w_lane_byte = bus.memReadData[7:0];
    case (r_lane)
      2'd0: w_lane_byte = bus.memReadData[7:0];
      2'd1: w_lane_byte = bus.memReadData[15:8];
      2'd2: w_lane_byte = bus.memReadData[23:16];
      2'd3: w_lane_byte = bus.memReadData[31:24];
      default: w_lane_byte = bus.memReadData[7:0];
    endcase
    w_lane_half = r_lane[1] ? bus.memReadData[31:16] : bus.memReadData[15:0];
    case (r_size)
      c_SIZE_BYTE: w_load_ext = {{24{~r_unsigned & w_lane_byte[7]}}, w_lane_byte};
      c_SIZE_HALF: w_load_ext = {{16{~r_unsigned & w_lane_half[15]}}, w_lane_half};
      default:     w_load_ext = bus.memReadData;
    endcase
  end

  // Store path: overlay the new byte/half onto the word read back in READ.
  always_comb begin
    w_merged = bus.memReadData;
    if (r_size == c_SIZE_BYTE) begin
      case (r_lane)
        2'd0: w_merged[7:0]   = r_wdata[7:0];
        2'd1: w_merged[15:8]  = r_wdata[7:0];
        2'd2: w_merged[23:16] = r_wdata[7:0];
        2'd3: w_merged[31:24] = r_wdata[7:0];
        default: w_merged = bus.memReadData;
      endcase
    end else if (r_lane[1]) begin
      w_merged[31:16] = r_wdata;
    end else begin
      w_merged[15:0] = r_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_write      <= 1'b0;
      r_size       <= 2'b00;
      r_unsigned   <= 1'b0;
      r_lane       <= 2'b00;
      r_wdata      <= 16'h0000;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_data  <= 32'h0;
      r_resp_error <= 1'b0;
      r_mem_addr   <= 32'h0;
      r_mem_rw     <= 1'b0;
      r_mem_wdata  <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_write      <= bus.reqWrite;
            r_size       <= bus.reqSize;
            r_unsigned   <= bus.reqUnsigned;
            r_lane       <= bus.reqAddress[1:0];
            r_wdata      <= bus.reqWriteData[15:0];
            r_req_ready  <= 1'b0;
            r_resp_error <= w_req_err;
            r_resp_data  <= 32'h0;
            if (w_req_err) begin
              // Rejected: answer straight away, memory is never touched.
              r_resp_valid <= 1'b1;
              r_state      <= S_RESP;
            end else begin
              r_mem_addr <= w_word_addr;
              if (bus.reqWrite && (bus.reqSize == c_SIZE_WORD)) begin
                r_mem_wdata <= bus.reqWriteData;
                r_mem_rw    <= 1'b1;
                r_state     <= S_WRITE;
              end else begin
                // Loads and sub-word stores both need the current word first.
                r_state <= S_READ;
              end
            end
          end
        end
        S_READ: begin
          if (r_write) begin
            r_mem_wdata <= w_merged;
            r_mem_rw    <= 1'b1;
            r_state     <= S_WRITE;
          end else begin
            r_resp_data  <= w_load_ext;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end
        end
        S_WRITE: begin
          r_mem_rw     <= 1'b0;
          r_resp_valid <= 1'b1;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          if (bus.respReady) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_mem_rw     <= 1'b0;
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b1;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.reqReady     = r_req_ready;
  assign bus.respValid    = r_resp_valid;
  assign bus.respReadData = r_resp_data;
  assign bus.respError    = r_resp_error;
  assign bus.memAddress   = r_mem_addr;
  assign bus.memReadWrite = r_mem_rw;
  assign bus.memWriteData = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_load_store_unit                                            |
// | Purpose  : Directed self-checking bench for load_store_unit with a       |
// |            behavioural ROM/RAM (addr bit 10 selects RAM, index [9:2]).   |
// | Options  : LSU_BOUNDS_CHECK_EN - selects expected result of the          |
// |            out-of-range load.                                            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_load_store_unit;

  logic clk;
  logic reset_n;
  load_store_unit_if bus();

  logic [31:0] ram [256];
  int n_checks;
  int n_errors;
  int wr_cnt;
  logic [31:0] last_wdata;

  load_store_unit #(.RAM_SELECT_BIT(10), .WORD_INDEX_BITS(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'hC0DE0000 | {22'h0, a[9:0]};
  endfunction

  assign bus.memReadData = bus.memAddress[10] ? ram[bus.memAddress[9:2]]
                                              : rom_word(bus.memAddress);

  always @(posedge clk) begin
    if (bus.memReadWrite) begin
      wr_cnt     <= wr_cnt + 1;
      last_wdata <= bus.memWriteData;
      if (bus.memAddress[10]) ram[bus.memAddress[9:2]] <= bus.memWriteData;
    end
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full transaction; lat = clock edges from accept edge (counted as 1)
  // up to and including the edge after which respValid is first seen.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] data, output logic err,
                        output int lat, output int nwr);
    int  w0;
    bit  seen;
    @(negedge clk);
    bus.reqWrite     = wr;
    bus.reqSize      = sz;
    bus.reqUnsigned  = uns;
    bus.reqAddress   = addr;
    bus.reqWriteData = wd;
    bus.reqValid     = 1'b1;
    w0 = wr_cnt;
    @(posedge clk);
    #1;
    bus.reqValid = 1'b0;
    lat  = 1;
    seen = bus.respValid;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      lat++;
      seen = bus.respValid;
    end
    if (!seen) check_value("resp_timeout", 32'd0, 32'd1);
    data = bus.respReadData;
    err  = bus.respError;
    bus.respReady = 1'b1;
    @(posedge clk);
    #1;
    bus.respReady = 1'b0;
    nwr = wr_cnt - w0;
  endtask

  logic [31:0] d;
  logic        e;
  int          lat;
  int          nw;
  int          w0;
  logic [31:0] held;

  initial begin
    n_checks = 0; n_errors = 0; wr_cnt = 0; last_wdata = 32'h0;
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    bus.reqValid = 1'b0; bus.reqWrite = 1'b0; bus.reqSize = 2'b00;
    bus.reqUnsigned = 1'b0; bus.reqAddress = 32'h0; bus.reqWriteData = 32'h0;
    bus.respReady = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_value("rst_reqReady",  {31'h0, bus.reqReady},     32'd1);
    check_value("rst_respValid", {31'h0, bus.respValid},    32'd0);
    check_value("rst_respError", {31'h0, bus.respError},    32'd0);
    check_value("rst_memRW",     {31'h0, bus.memReadWrite}, 32'd0);
    check_value("rst_memAddr",   bus.memAddress,            32'h0);
    check_value("rst_memWdata",  bus.memWriteData,          32'h0);
    check_value("rst_respData",  bus.respReadData,          32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Word store then load back
    do_req(1'b1, 2'b10, 1'b0, 32'h400, 32'h11223344, d, e, lat, nw);
    check_value("sw_err",    {31'h0, e}, 32'd0);
    check_value("sw_writes", nw,         32'd1);
    check_value("sw_wdata",  last_wdata, 32'h11223344);
    check_value("sw_lat",    lat,        32'd2);
    do_req(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, d, e, lat, nw);
    check_value("lw_data", d,          32'h11223344);
    check_value("lw_err",  {31'h0, e}, 32'd0);
    check_value("lw_lat",  lat,        32'd2);

    // Byte store read-modify-write
    do_req(1'b1, 2'b00, 1'b0, 32'h401, 32'h000000AA, d, e, lat, nw);
    check_value("sb_writes", nw,         32'd1);
    check_value("sb_wdata",  last_wdata, 32'h1122AA44);
    check_value("sb_err",    {31'h0, e}, 32'd0);
    check_value("sb_lat",    lat,        32'd3);
    do_req(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, d, e, lat, nw);
    check_value("lw_after_sb", d, 32'h1122AA44);

    // Sub-word loads
    do_req(1'b0, 2'b00, 1'b0, 32'h401, 32'h0, d, e, lat, nw);
    check_value("lb_401", d, 32'hFFFFFFAA);
    do_req(1'b0, 2'b00, 1'b1, 32'h401, 32'h0, d, e, lat, nw);
    check_value("lbu_401", d, 32'h000000AA);
    do_req(1'b0, 2'b01, 1'b0, 32'h402, 32'h0, d, e, lat, nw);
    check_value("lh_402", d, 32'h00001122);
    do_req(1'b0, 2'b01, 1'b0, 32'h400, 32'h0, d, e, lat, nw);
    check_value("lh_400", d, 32'hFFFFAA44);
    do_req(1'b0, 2'b01, 1'b1, 32'h400, 32'h0, d, e, lat, nw);
    check_value("lhu_400", d, 32'h0000AA44);
    do_req(1'b0, 2'b00, 1'b0, 32'h403, 32'h0, d, e, lat, nw);
    check_value("lb_403", d, 32'h00000011);

    // Half store to upper half
    do_req(1'b1, 2'b10, 1'b0, 32'h408, 32'h12345678, d, e, lat, nw);
    do_req(1'b1, 2'b01, 1'b0, 32'h40A, 32'hCAFEBEEF, d, e, lat, nw);
    check_value("sh_wdata",  last_wdata, 32'hBEEF5678);
    check_value("sh_writes", nw,         32'd1);

    // ROM load
    do_req(1'b0, 2'b10, 1'b0, 32'h010, 32'h0, d, e, lat, nw);
    check_value("rom_lw", d, 32'hC0DE0010);
    check_value("rom_lw_err", {31'h0, e}, 32'd0);

    // Error cases
    do_req(1'b0, 2'b10, 1'b0, 32'h402, 32'h0, d, e, lat, nw);
    check_value("lw_mis_err", {31'h0, e}, 32'd1);
    check_value("lw_mis_data", d, 32'h0);
    check_value("lw_mis_wr", nw, 32'd0);
    check_value("lw_mis_lat", lat, 32'd1);
    do_req(1'b1, 2'b01, 1'b0, 32'h403, 32'h5555, d, e, lat, nw);
    check_value("sh_mis_err", {31'h0, e}, 32'd1);
    check_value("sh_mis_data", d, 32'h0);
    check_value("sh_mis_wr", nw, 32'd0);
    do_req(1'b1, 2'b10, 1'b0, 32'h010, 32'h99999999, d, e, lat, nw);
    check_value("sw_rom_err", {31'h0, e}, 32'd1);
    check_value("sw_rom_data", d, 32'h0);
    check_value("sw_rom_wr", nw, 32'd0);
    do_req(1'b0, 2'b11, 1'b0, 32'h400, 32'h0, d, e, lat, nw);
    check_value("size11_err", {31'h0, e}, 32'd1);
    check_value("size11_data", d, 32'h0);

    // Response back-pressure
    @(negedge clk);
    bus.reqWrite = 1'b0; bus.reqSize = 2'b10; bus.reqUnsigned = 1'b0;
    bus.reqAddress = 32'h400; bus.reqValid = 1'b1;
    @(posedge clk);
    #1;
    bus.reqValid = 1'b0;
    check_value("hold_read_valid", {31'h0, bus.respValid}, 32'd0);
    @(posedge clk);
    #1;
    check_value("hold_first_valid", {31'h0, bus.respValid}, 32'd1);
    held = bus.respReadData;
    check_value("hold_first_data", held, 32'h1122AA44);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_value("hold_valid", {31'h0, bus.respValid}, 32'd1);
      check_value("hold_data",  bus.respReadData,      32'h1122AA44);
      check_value("hold_ready", {31'h0, bus.reqReady}, 32'd0);
    end
    bus.respReady = 1'b1;
    @(posedge clk);
    #1;
    bus.respReady = 1'b0;
    check_value("post_hs_ready", {31'h0, bus.reqReady},  32'd1);
    check_value("post_hs_valid", {31'h0, bus.respValid}, 32'd0);

    // Reset during the write cycle of a byte store
    do_req(1'b1, 2'b10, 1'b0, 32'h404, 32'hDEADBEEF, d, e, lat, nw);
    w0 = wr_cnt;
    @(negedge clk);
    bus.reqWrite = 1'b1; bus.reqSize = 2'b00; bus.reqAddress = 32'h405;
    bus.reqWriteData = 32'h000000BB; bus.reqValid = 1'b1;
    @(posedge clk);
    #1;
    bus.reqValid = 1'b0;
    @(posedge clk);
    #1;
    check_value("rst_mid_in_write", {31'h0, bus.memReadWrite}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_value("rst_mid_memRW",  {31'h0, bus.memReadWrite}, 32'd0);
    check_value("rst_mid_ready",  {31'h0, bus.reqReady},     32'd1);
    check_value("rst_mid_valid",  {31'h0, bus.respValid},    32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_value("rst_rel_ready", {31'h0, bus.reqReady},  32'd1);
    check_value("rst_rel_valid", {31'h0, bus.respValid}, 32'd0);
    check_value("rst_no_write",  wr_cnt - w0,            32'd0);
    do_req(1'b0, 2'b10, 1'b0, 32'h404, 32'h0, d, e, lat, nw);
    check_value("rst_word_kept", d, 32'hDEADBEEF);

    // Address above the decoded range
    do_req(1'b0, 2'b10, 1'b0, 32'h00000C00, 32'h0, d, e, lat, nw);
`ifdef LSU_BOUNDS_CHECK_EN
    check_value("oob_err",  {31'h0, e}, 32'd1);
    check_value("oob_data", d,          32'h0);
`else
    check_value("alias_err",  {31'h0, e}, 32'd0);
    check_value("alias_data", d,          32'h1122AA44);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
